cadence_assist_drive: RTL and testbench

- Downstream consumer of cadence_meas: converts cadence_per/not_pedaling plus averaged torque, incline and assist scale into the motor target current.
- 4-stage pipeline: cadence lookup, torque/incline conditioning, multiply, saturate.
- Followed by a slew-limited output register that feeds the current-loop PI block.
- Advances only on a valid strobe; no backpressure.

---
 rtl/ebike_pkg.sv | 56 +++++
 rtl/cadence_factor_lu.sv | 33 +++
 rtl/cadence_assist_drive.sv | 130 +++++++++++++
 tb/tb_cadence_assist_drive.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ebike_pkg.sv
//------------------------------------------------------------------------------
// ebike_pkg : shared widths, cadence table and incline limits for the assist path
// Revision  : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ebike_pkg;

  localparam int c_per_w   = 8;
  localparam int c_fac_w   = 6;
  localparam int c_trq_w   = 12;
  localparam int c_inc_w   = 13;
  localparam int c_incf_w  = 9;
  localparam int c_scale_w = 3;
  localparam int c_p1_w    = 21;
  localparam int c_p2_w    = 9;
  localparam int c_prod_w  = 30;
  localparam int c_cur_w   = 12;

  localparam logic [c_trq_w-1:0] c_torque_min_def = 12'h380;

  // Cadence period thresholds (inclusive upper bounds) and their factors
  localparam logic [c_per_w-1:0] c_cad_thr_0 = 8'h10;
  localparam logic [c_per_w-1:0] c_cad_thr_1 = 8'h18;
  localparam logic [c_per_w-1:0] c_cad_thr_2 = 8'h20;
  localparam logic [c_per_w-1:0] c_cad_thr_3 = 8'h30;
  localparam logic [c_per_w-1:0] c_cad_thr_4 = 8'h48;
  localparam logic [c_per_w-1:0] c_cad_thr_5 = 8'h70;

  localparam logic [c_fac_w-1:0] c_cad_fac_0    = 6'd32;
  localparam logic [c_fac_w-1:0] c_cad_fac_1    = 6'd28;
  localparam logic [c_fac_w-1:0] c_cad_fac_2    = 6'd24;
  localparam logic [c_fac_w-1:0] c_cad_fac_3    = 6'd18;
  localparam logic [c_fac_w-1:0] c_cad_fac_4    = 6'd12;
  localparam logic [c_fac_w-1:0] c_cad_fac_5    = 6'd8;
  localparam logic [c_fac_w-1:0] c_cad_fac_slow = 6'd4;

  localparam logic signed [c_inc_w-1:0] c_inc_clip_lo = -13'sd256;
  localparam logic signed [c_inc_w-1:0] c_inc_clip_hi = 13'sd255;
  localparam logic signed [c_inc_w-1:0] c_inc_bias    = 13'sd256;

  // Clip the signed incline and bias it into an unsigned 0..511 factor
  function automatic logic [c_incf_w-1:0] incline_factor(input logic signed [c_inc_w-1:0] inc);
    logic signed [c_inc_w-1:0] clipped;
    if (inc < c_inc_clip_lo)
      clipped = c_inc_clip_lo;
    else if (inc > c_inc_clip_hi)
      clipped = c_inc_clip_hi;
    else
      clipped = inc;
    return 9'(clipped + c_inc_bias);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cadence_factor_lu.sv
//------------------------------------------------------------------------------
// cadence_factor_lu : combinational pedal period -> cadence factor table
// Revision          : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cadence_factor_lu
  import ebike_pkg::*;
(
  input  logic [c_per_w-1:0] i_per,
  output logic [c_fac_w-1:0] o_factor
);

  // First matching threshold wins; shorter period means faster pedalling
  always_comb begin
    o_factor = c_cad_fac_slow;
    if (i_per <= c_cad_thr_0)
      o_factor = c_cad_fac_0;
    else if (i_per <= c_cad_thr_1)
      o_factor = c_cad_fac_1;
    else if (i_per <= c_cad_thr_2)
      o_factor = c_cad_fac_2;
    else if (i_per <= c_cad_thr_3)
      o_factor = c_cad_fac_3;
    else if (i_per <= c_cad_thr_4)
      o_factor = c_cad_fac_4;
    else if (i_per <= c_cad_thr_5)
      o_factor = c_cad_fac_5;
  end

endmodule

`default_nettype wire

// File: rtl/cadence_assist_drive.sv
//------------------------------------------------------------------------------
// cadence_assist_drive : 4-stage assist current pipeline with slew-limited output
// Revision             : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cadence_assist_drive
  import ebike_pkg::*;
#(
  parameter logic [c_trq_w-1:0] TORQUE_MIN = c_torque_min_def,
  parameter logic [c_cur_w-1:0] SLEW_STEP  = 12'h100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vld_in,
  input  logic [c_per_w-1:0]          cadence_per,
  input  logic                        not_pedaling,
  input  logic [c_trq_w-1:0]          avg_torque,
  input  logic signed [c_inc_w-1:0]   incline,
  input  logic [c_scale_w-1:0]        scale,
  output logic [c_cur_w-1:0]          target_curr,
  output logic                        vld_out
);

  logic [c_fac_w-1:0]   w_cad_lu;
  logic [c_trq_w-1:0]   w_torque_pos;

  logic                 r_s1_vld;
  logic [c_fac_w-1:0]   r_cad_fac;
  logic [c_trq_w-1:0]   r_torque_pos;
  logic [c_incf_w-1:0]  r_inc_fac;
  logic [c_scale_w-1:0] r_scale;

  logic                 r_s2_vld;
  logic [c_p1_w-1:0]    r_p1;
  logic [c_p2_w-1:0]    r_p2;

  logic                 r_s3_vld;
  logic [c_prod_w-1:0]  r_prod;

  logic                 r_s4_vld;
  logic [c_cur_w-1:0]   r_raw;

  logic [c_cur_w:0]     w_raw_x;
  logic [c_cur_w:0]     w_tgt_x;
  logic [c_cur_w:0]     w_step_x;
  logic [c_cur_w:0]     w_diff;
  logic                 w_up;
  logic [c_cur_w-1:0]   w_next;

  cadence_factor_lu u_cad_lu (
    .i_per    (cadence_per),
    .o_factor (w_cad_lu)
  );

  assign w_torque_pos = (avg_torque > TORQUE_MIN) ? (avg_torque - TORQUE_MIN) : '0;

  // Stage valids shift every clock; data registers load only behind a valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld     <= 1'b0;
      r_cad_fac    <= '0;
      r_torque_pos <= '0;
      r_inc_fac    <= '0;
      r_scale      <= '0;
      r_s2_vld     <= 1'b0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_s3_vld     <= 1'b0;
      r_prod       <= '0;
      r_s4_vld     <= 1'b0;
      r_raw        <= '0;
    end else begin
      r_s1_vld <= vld_in;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_s4_vld <= r_s3_vld;

      if (vld_in) begin
        r_cad_fac    <= not_pedaling ? '0 : w_cad_lu;
        r_torque_pos <= w_torque_pos;
        r_inc_fac    <= incline_factor(incline);
        r_scale      <= scale;
      end

      if (r_s1_vld) begin
        r_p1 <= {9'd0, r_torque_pos} * {12'd0, r_inc_fac};
        r_p2 <= {3'd0, r_cad_fac} * {6'd0, r_scale};
      end

      if (r_s2_vld)
        r_prod <= {9'd0, r_p1} * {21'd0, r_p2};

      // Anything at or above 2^27 would overflow the 12-bit window
      if (r_s3_vld)
        r_raw <= (|r_prod[29:27]) ? 12'hFFF : r_prod[26:15];
    end
  end

  assign w_raw_x  = {1'b0, r_raw};
  assign w_tgt_x  = {1'b0, target_curr};
  assign w_step_x = {1'b0, SLEW_STEP};
  assign w_up     = (w_raw_x >= w_tgt_x);
  assign w_diff   = w_up ? (w_raw_x - w_tgt_x) : (w_tgt_x - w_raw_x);

  // A full step is only taken when the gap exceeds it, so no wrap is possible
  always_comb begin
    w_next = r_raw;
    if (w_diff > w_step_x) begin
      if (w_up)
        w_next = target_curr + SLEW_STEP;
      else
        w_next = target_curr - SLEW_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_curr <= '0;
      vld_out     <= 1'b0;
    end else begin
      vld_out <= r_s4_vld;
      if (r_s4_vld)
        target_curr <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cadence_assist_drive.sv
//------------------------------------------------------------------------------
// tb_cadence_assist_drive : directed bench, default-slew and unlimited-slew DUTs
// Revision                : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cadence_assist_drive;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld_in = 1'b0;
  logic [7:0]         cadence_per = '0;
  logic               not_pedaling = 1'b0;
  logic [11:0]        avg_torque = '0;
  logic signed [12:0] incline = '0;
  logic [2:0]         scale = '0;

  logic [11:0] tgt_def, tgt_ff;
  logic        vo_def, vo_ff;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cadence_assist_drive u_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_in       (vld_in),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling),
    .avg_torque   (avg_torque),
    .incline      (incline),
    .scale        (scale),
    .target_curr  (tgt_def),
    .vld_out      (vo_def)
  );

  cadence_assist_drive #(.SLEW_STEP(12'hFFF)) u_ff (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_in       (vld_in),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling),
    .avg_torque   (avg_torque),
    .incline      (incline),
    .scale        (scale),
    .target_curr  (tgt_ff),
    .vld_out      (vo_ff)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] per, input logic np, input logic [11:0] tq,
                       input logic [12:0] inc, input logic [2:0] sc);
    cadence_per  = per;
    not_pedaling = np;
    avg_torque   = tq;
    incline      = inc;
    scale        = sc;
    vld_in       = 1'b1;
    step(1);
  endtask

  // One isolated sample, then wait until its vld_out cycle
  task automatic send(input logic [7:0] per, input logic np, input logic [11:0] tq,
                      input logic [12:0] inc, input logic [2:0] sc);
    drive(per, np, tq, inc, sc);
    vld_in = 1'b0;
    step(4);
  endtask

  task automatic send_nom();
    send(8'h10, 1'b0, 12'h780, 13'h0000, 3'd4);
  endtask

  task automatic send_sat();
    send(8'h08, 1'b0, 12'hFFF, 13'h0FFF, 3'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    // Reset state
    step(3);
    chk("rst_tgt_def", tgt_def, 12'h000);
    chk("rst_tgt_ff",  tgt_ff,  12'h000);
    chk("rst_vo_def",  {11'd0, vo_def}, 12'h000);
    chk("rst_vo_ff",   {11'd0, vo_ff},  12'h000);
    rst_n = 1'b1;
    step(2);

    // Nominal: prod = 2^25 -> raw 0x400
    send_nom();
    chk("nom_vo_ff",  {11'd0, vo_ff}, 12'h001);
    chk("nom_tgt_ff", tgt_ff,  12'h400);
    chk("slew1_def",  tgt_def, 12'h100);
    step(1);
    chk("nom_pulse_low", {11'd0, vo_ff}, 12'h000);

    // Default slew climbs by 0x100 per result, then holds
    step(4);
    send_nom();
    chk("slew2_def", tgt_def, 12'h200);
    step(5);
    send_nom();
    chk("slew3_def", tgt_def, 12'h300);
    step(5);
    send_nom();
    chk("slew4_def", tgt_def, 12'h400);
    step(5);
    send_nom();
    chk("slew5_def", tgt_def, 12'h400);
    step(10);
    chk("hold_def", tgt_def, 12'h400);
    chk("hold_vo",  {11'd0, vo_def}, 12'h000);

    // Not pedaling decays at SLEW_STEP per result
    send(8'h10, 1'b1, 12'h780, 13'h0000, 3'd4);
    chk("np1_def", tgt_def, 12'h300);
    chk("np1_ff",  tgt_ff,  12'h000);
    step(3);
    send(8'h10, 1'b1, 12'h780, 13'h0000, 3'd4);
    chk("np2_def", tgt_def, 12'h200);
    step(3);
    send(8'h10, 1'b1, 12'h780, 13'h0000, 3'd4);
    chk("np3_def", tgt_def, 12'h100);
    step(3);
    send(8'h10, 1'b1, 12'h780, 13'h0000, 3'd4);
    chk("np4_def", tgt_def, 12'h000);
    step(3);

    // Saturation
    send_sat();
    chk("sat_ff",  tgt_ff,  12'hFFF);
    chk("sat_def", tgt_def, 12'h100);
    step(3);

    // Zero paths
    send(8'h10, 1'b0, 12'h380, 13'h0000, 3'd4);
    chk("zero_torque_ff", tgt_ff, 12'h000);
    step(3);
    send_sat();
    step(3);
    send(8'h08, 1'b0, 12'hFFF, 13'h1F00, 3'd7);
    chk("zero_incline_ff", tgt_ff, 12'h000);
    step(3);
    send_sat();
    step(3);
    send(8'h08, 1'b0, 12'hFFF, 13'h0FFF, 3'd0);
    chk("zero_scale_ff", tgt_ff, 12'h000);
    step(3);

    // Back-to-back throughput across cadence table boundaries
    drive(8'h10, 1'b0, 12'h780, 13'h0000, 3'd4);
    drive(8'h11, 1'b0, 12'h780, 13'h0000, 3'd4);
    drive(8'h70, 1'b0, 12'h780, 13'h0000, 3'd4);
    drive(8'h71, 1'b0, 12'h780, 13'h0000, 3'd4);
    vld_in = 1'b0;
    step(1);
    chk("tp0_vo", {11'd0, vo_ff}, 12'h001);
    chk("tp0_ff", tgt_ff, 12'h400);
    step(1);
    chk("tp1_vo", {11'd0, vo_ff}, 12'h001);
    chk("tp1_ff", tgt_ff, 12'h380);
    step(1);
    chk("tp2_vo", {11'd0, vo_ff}, 12'h001);
    chk("tp2_ff", tgt_ff, 12'h100);
    step(1);
    chk("tp3_vo", {11'd0, vo_ff}, 12'h001);
    chk("tp3_ff", tgt_ff, 12'h080);
    step(1);
    chk("tp_end_vo", {11'd0, vo_ff}, 12'h000);
    step(3);

    // Mid-stream reset with three samples in flight
    drive(8'h10, 1'b0, 12'h780, 13'h0000, 3'd4);
    drive(8'h11, 1'b0, 12'h780, 13'h0000, 3'd4);
    drive(8'h70, 1'b0, 12'h780, 13'h0000, 3'd4);
    vld_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mrst_tgt_ff", tgt_ff, 12'h000);
    chk("mrst_vo_ff",  {11'd0, vo_ff}, 12'h000);
    chk("mrst_tgt_def", tgt_def, 12'h000);
    step(2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (vo_ff || vo_def) seen = 1'b1;
    end
    chk("mrst_no_pulse", {11'd0, seen}, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
